key_conditioner: RTL

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronises and debounces three active-low keys,
// generates press/auto-repeat events for left/right, and hands them to a
// consumer through a held-command / ack handshake. Start is a one-cycle pulse.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_start_n,
  input  logic ack,
  output logic left,
  output logic right,
  output logic start,
  output logic overrun
);

  localparam int unsigned NKEYS  = 3;
  localparam int unsigned K_L    = 0;
  localparam int unsigned K_R    = 1;
  localparam int unsigned K_S    = 2;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  typedef enum logic [1:0] {IDLE, PEND_L, PEND_R, DRAIN} state_t;

  logic [NKEYS-1:0] sync1_q, sync1_d;
  logic [NKEYS-1:0] sync2_q, sync2_d;
  logic [NKEYS-1:0] stable_q, stable_d;
  logic [NKEYS-1:0] prev_q, prev_d;
  logic [DB_W-1:0]  db_cnt_q [NKEYS];
  logic [DB_W-1:0]  db_cnt_d [NKEYS];

  logic [RP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic             rep_arm_q, rep_arm_d;

  logic [NKEYS-1:0] press;
  logic             one_hot;
  logic             press_l_ok, press_r_ok, press_ok;
  logic             rep_active, rep_fire;
  logic [RP_W-1:0]  rep_target;
  logic             ev_l, ev_r;

  state_t           state_q;

  // Synchroniser and per-key debounce: a level change is accepted after it
  // has been seen on DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    sync1_d  = ~{key_start_n, key_right_n, key_left_n};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int i = 0; i < int'(NKEYS); i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Press detection and auto-repeat; repeats only follow a press that was
  // valid on its own, so releasing one of two held keys never re-arms.
  always_comb begin
    press      = stable_q & ~prev_q;
    one_hot    = stable_q[K_L] ^ stable_q[K_R];
    press_l_ok = press[K_L] & ~stable_q[K_R];
    press_r_ok = press[K_R] & ~stable_q[K_L];
    press_ok   = press_l_ok | press_r_ok;
    rep_active = one_hot & (rep_arm_q | press_ok);
    rep_target = rep_phase_q ? RP_W'(REPEAT_PERIOD) : RP_W'(REPEAT_DELAY);
    rep_fire   = rep_active & ~press_ok & (rep_cnt_q >= rep_target);
    rep_arm_d  = rep_active;
    rep_cnt_d  = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    if (!rep_active) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (press_ok) begin
      rep_cnt_d   = RP_W'(1);
      rep_phase_d = 1'b0;
    end else if (rep_fire) begin
      rep_cnt_d   = RP_W'(1);
      rep_phase_d = 1'b1;
    end else begin
      rep_cnt_d   = rep_cnt_q + RP_W'(1);
    end
    ev_l = press_l_ok | (rep_fire & stable_q[K_L]);
    ev_r = press_r_ok | (rep_fire & stable_q[K_R]);
  end

  // Key path registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      rep_arm_q   <= 1'b0;
      for (int i = 0; i < int'(NKEYS); i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      rep_arm_q   <= rep_arm_d;
      for (int i = 0; i < int'(NKEYS); i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Command FSM with registered outputs; events while busy are dropped and
  // latch the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      left    <= 1'b0;
      right   <= 1'b0;
      start   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      start <= press[K_S];
      if ((state_q != IDLE) && (ev_l || ev_r)) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (ev_l) begin
            state_q <= PEND_L;
            left    <= 1'b1;
          end else if (ev_r) begin
            state_q <= PEND_R;
            right   <= 1'b1;
          end
        end
        PEND_L: begin
          if (ack) begin
            state_q <= DRAIN;
            left    <= 1'b0;
          end
        end
        PEND_R: begin
          if (ack) begin
            state_q <= DRAIN;
            right   <= 1'b0;
          end
        end
        DRAIN: begin
          if (!ack) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          left    <= 1'b0;
          right   <= 1'b0;
        end
      endcase
    end
  end

endmodule
